// File: rtl/music_seq_ctrl.sv
// music_seq_ctrl: walks a score ROM of {note, dur} entries, drives the tone generator,
// beat tick and LED freeze level. Build macro MUSIC_LOOP_EN makes the score loop forever.
module music_seq_ctrl #(
   parameter int unsigned BEAT_CYCLES = 5000000,
   parameter int unsigned GAP_CYCLES  = 500000,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned NOTE_W      = 5,
   parameter int unsigned DUR_W       = 4
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    PLAY,
   input  logic                    PAUSE,
   input  logic                    STOP,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [NOTE_W+DUR_W-1:0] rom_data,
   output logic [NOTE_W-1:0]       note,
   output logic                    note_on,
   output logic                    beat_tick,
   output logic                    led_freeze,
   output logic [2:0]              state,
   output logic                    done
);

   localparam int unsigned CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_START = CNT_W'(BEAT_CYCLES - GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_PLAY   = 3'd3,
      S_PAUSED = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [NOTE_W-1:0]   note_q, note_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DUR_W-1:0]    beats_q, beats_d;
   logic                pend_q, pend_d;
   logic                note_on_q, note_on_d;
   logic                tick_q, tick_d;
   logic                freeze_q, freeze_d;
   logic                done_q, done_d;

   logic [NOTE_W-1:0]   rom_note;
   logic [DUR_W-1:0]    rom_dur;

   assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur  = rom_data[DUR_W-1:0];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      note_d  = note_q;
      cnt_d   = cnt_q;
      beats_d = beats_q;
      pend_d  = pend_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;

      if (STOP) begin
         state_d = S_IDLE;
         addr_d  = '0;
         note_d  = '0;
         cnt_d   = '0;
         beats_d = '0;
         pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (PLAY) state_d = S_FETCH;
            end
            S_FETCH: begin
               pend_d  = pend_q | PAUSE;
               state_d = S_LOAD;
            end
            S_LOAD: begin
               pend_d = pend_q | PAUSE;
               if (rom_dur == '0) begin
                  done_d = 1'b1;
                  addr_d = '0;
`ifdef MUSIC_LOOP_EN
                  state_d = S_FETCH;
`else
                  state_d = S_IDLE;
                  pend_d  = 1'b0;
`endif
               end else begin
                  note_d  = rom_note;
                  beats_d = rom_dur;
                  cnt_d   = '0;
                  state_d = S_PLAY;
               end
            end
            S_PLAY: begin
               // A pause requested during FETCH/LOAD is honoured here, before any counting
               if (PAUSE || pend_q) begin
                  state_d = S_PAUSED;
                  pend_d  = 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  tick_d  = 1'b1;
                  beats_d = beats_q - DUR_W'(1);
                  if (beats_q == DUR_W'(1)) begin
                     addr_d  = addr_q + ADDR_W'(1);
                     state_d = S_FETCH;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_PAUSED: begin
               if (PLAY) state_d = S_PLAY;
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Tone follows the counter one cycle late, silenced across the tail gap of the last beat
      note_on_d = (state_q == S_PLAY) && (state_d == S_PLAY) && (note_q != '0) &&
                  !((beats_q == DUR_W'(1)) && (cnt_q >= GAP_START));
      freeze_d  = (state_d == S_IDLE) || (state_d == S_PAUSED);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         note_q    <= '0;
         cnt_q     <= '0;
         beats_q   <= '0;
         pend_q    <= 1'b0;
         note_on_q <= 1'b0;
         tick_q    <= 1'b0;
         freeze_q  <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         note_q    <= note_d;
         cnt_q     <= cnt_d;
         beats_q   <= beats_d;
         pend_q    <= pend_d;
         note_on_q <= note_on_d;
         tick_q    <= tick_d;
         freeze_q  <= freeze_d;
         done_q    <= done_d;
      end
   end

   assign rom_addr   = addr_q;
   assign note       = note_q;
   assign note_on    = note_on_q;
   assign beat_tick  = tick_q;
   assign led_freeze = freeze_q;
   assign state      = state_q;
   assign done       = done_q;

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Bench for music_seq_ctrl: directed table, hand-written corner sequences and random
// command pulses, all checked against a note-position reference model.
module tb_music_seq_ctrl;

   localparam int BEAT = 8;
   localparam int GAP  = 2;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       PLAY, PAUSE, STOP;
   logic [7:0] rom_addr;
   logic [8:0] rom_data = '0;
   logic [4:0] note;
   logic       note_on, beat_tick, led_freeze, done;
   logic [2:0] state;

   logic [8:0] rom_mem [0:255];

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: position-in-note view of the sequencer
   int m_st, m_addr, m_note, m_pos, m_dur, m_pend;
   int exp_on, exp_tick, exp_done, exp_freeze;

   typedef struct {
      logic pl, pa, sp;
      int   st, addr, nt;
      logic on, tk, fz, dn;
   } vec_t;
   vec_t tbl [0:10];

   music_seq_ctrl #(
      .BEAT_CYCLES(BEAT),
      .GAP_CYCLES (GAP),
      .ADDR_W     (8),
      .NOTE_W     (5),
      .DUR_W      (4)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .PLAY      (PLAY),
      .PAUSE     (PAUSE),
      .STOP      (STOP),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .note      (note),
      .note_on   (note_on),
      .beat_tick (beat_tick),
      .led_freeze(led_freeze),
      .state     (state),
      .done      (done)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) rom_data <= rom_mem[rom_addr];

   function automatic void chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endfunction

   task automatic model_reset();
      m_st = 0; m_addr = 0; m_note = 0; m_pos = 0; m_dur = 0; m_pend = 0;
      exp_on = 0; exp_tick = 0; exp_done = 0; exp_freeze = 1;
   endtask

   task automatic model_step(input logic pl, input logic pa, input logic sp);
      logic [8:0] e;
      exp_on = 0; exp_tick = 0; exp_done = 0;
      if (sp) begin
         m_st = 0; m_addr = 0; m_note = 0; m_pos = 0; m_dur = 0; m_pend = 0;
      end else begin
         case (m_st)
            0: if (pl) m_st = 1;
            1: begin
               if (pa) m_pend = 1;
               m_st = 2;
            end
            2: begin
               if (pa) m_pend = 1;
               e = rom_mem[m_addr];
               if (e[3:0] == 0) begin
                  exp_done = 1;
                  m_addr = 0;
`ifdef MUSIC_LOOP_EN
                  m_st = 1;
`else
                  m_st = 0;
                  m_pend = 0;
`endif
               end else begin
                  m_note = int'(e[8:4]);
                  m_dur  = int'(e[3:0]);
                  m_pos  = 0;
                  m_st   = 3;
               end
            end
            3: begin
               if (pa || m_pend != 0) begin
                  m_st = 4;
                  m_pend = 0;
               end else begin
                  exp_on = (m_note != 0 && m_pos < m_dur * BEAT - GAP) ? 1 : 0;
                  if (m_pos % BEAT == BEAT - 1) exp_tick = 1;
                  m_pos++;
                  if (m_pos == m_dur * BEAT) begin
                     m_addr = (m_addr + 1) % 256;
                     m_pos = 0;
                     m_st = 1;
                  end
               end
            end
            4: if (pl) m_st = 3;
            default: m_st = 0;
         endcase
      end
      exp_freeze = (m_st == 0 || m_st == 4) ? 1 : 0;
   endtask

   task automatic compare_all();
      chk("state", int'(state), m_st);
      chk("rom_addr", int'(rom_addr), m_addr);
      chk("note", int'(note), m_note);
      chk("note_on", int'(note_on), exp_on);
      chk("beat_tick", int'(beat_tick), exp_tick);
      chk("led_freeze", int'(led_freeze), exp_freeze);
      chk("done", int'(done), exp_done);
   endtask

   task automatic cyc(input logic pl, input logic pa, input logic sp);
      PLAY = pl; PAUSE = pa; STOP = sp;
      @(posedge CLK);
      model_step(pl, pa, sp);
      #1;
      PLAY = 1'b0; PAUSE = 1'b0; STOP = 1'b0;
      compare_all();
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      #3;
      model_reset();
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      compare_all();
   endtask

   initial begin
      int first_on, on3, on7, rest_play, done_at, n;
      int ticks[$];
      int addrs[$];
      int last_addr;
      int r;

      for (int i = 0; i < 256; i++) rom_mem[i] = 9'd0;
      rom_mem[0] = {5'd3, 4'd2};
      rom_mem[1] = {5'd0, 4'd1};
      rom_mem[2] = {5'd7, 4'd1};
      rom_mem[3] = {5'd9, 4'd0};

      //              pl pa sp  st addr nt on tk fz dn
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 3, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 3, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 3, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 4, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 4, 0, 3, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 3, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 3, 0, 3, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};

      PLAY = 1'b0; PAUSE = 1'b0; STOP = 1'b0;
      RST_N = 1'b0;
      model_reset();
      @(posedge CLK);
      #1;
      compare_all();
      RST_N = 1'b1;

      for (int i = 0; i <= 10; i++) begin
         cyc(tbl[i].pl, tbl[i].pa, tbl[i].sp);
         chk("tbl_state", int'(state), tbl[i].st);
         chk("tbl_addr", int'(rom_addr), tbl[i].addr);
         chk("tbl_note", int'(note), tbl[i].nt);
         chk("tbl_on", int'(note_on), int'(tbl[i].on));
         chk("tbl_tick", int'(beat_tick), int'(tbl[i].tk));
         chk("tbl_freeze", int'(led_freeze), int'(tbl[i].fz));
         chk("tbl_done", int'(done), int'(tbl[i].dn));
      end

      // full song playback
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      first_on = -1; on3 = 0; on7 = 0; rest_play = 0; done_at = -1; last_addr = 0;
      for (int i = 1; i <= 60 && done_at < 0; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         if (note_on && first_on < 0) first_on = i;
         if (note_on && note == 5'd3) on3++;
         if (note_on && note == 5'd7) on7++;
         if (state == 3'd3 && note == 5'd0) rest_play++;
         if (beat_tick) ticks.push_back(i);
         if (int'(rom_addr) != last_addr) begin
            addrs.push_back(int'(rom_addr));
            last_addr = int'(rom_addr);
         end
         if (done) begin
            done_at = i;
            chk("end_state", int'(state), 0);
            chk("end_addr", int'(rom_addr), 0);
            chk("end_freeze", int'(led_freeze), 1);
         end
      end
      chk("done_cycle", done_at, 40);
      chk("first_note_on", first_on, 3);
      chk("note3_on_cycles", on3, 14);
      chk("note7_on_cycles", on7, 6);
      chk("rest_play_cycles", rest_play, 8);
      chk("tick_count", ticks.size(), 4);
      if (ticks.size() >= 2) chk("tick_spacing", ticks[1] - ticks[0], 8);
      else chk("tick_spacing", ticks.size(), 2);
      chk("addr_steps", addrs.size(), 4);
      for (int i = 0; i < 4 && i < addrs.size(); i++) chk("addr_seq", addrs[i], (i + 1) % 4);

      // pause at counter 5 of note 3, resume
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20 && !(m_st == 3 && m_pos == 5); i++) cyc(1'b0, 1'b0, 1'b0);
      chk("reach_cnt5", m_pos, 5);
      cyc(1'b0, 1'b1, 1'b0);
      chk("pause_state", int'(state), 4);
      chk("pause_on", int'(note_on), 0);
      chk("pause_freeze", int'(led_freeze), 1);
      repeat (20) cyc(1'b0, 1'b0, 1'b0);
      chk("paused_hold", int'(state), 4);
      cyc(1'b1, 1'b0, 1'b0);
      n = -1;
      for (int i = 1; i <= 6 && n < 0; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         if (beat_tick) n = i;
      end
      chk("tick_after_resume", n, 3);

      // pause requested during FETCH is taken on the first PLAY cycle
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("defer_play", int'(state), 3);
      cyc(1'b0, 1'b0, 1'b0);
      chk("defer_paused", int'(state), 4);

      // coincident commands
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("all_cmds", int'(state), 0);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      chk("pause_play", int'(state), 4);

      // asynchronous reset mid-note
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      repeat (6) cyc(1'b0, 1'b0, 1'b0);
      chk("pre_reset_on", int'(note_on), 1);
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("async_freeze", int'(led_freeze), 1);
      @(posedge CLK);
      #1;
      compare_all();
      RST_N = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      chk("restart_note", int'(note), 3);
      chk("restart_on", int'(note_on), 1);

      // random command pulses against the model
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 63);
         if (r < 7)       cyc(1'b1, 1'b0, 1'b0);
         else if (r < 9)  cyc(1'b0, 1'b1, 1'b0);
         else if (r == 9) cyc(1'b0, 1'b0, 1'b1);
         else if (r == 10) cyc(1'b1, 1'b1, 1'b0);
         else if (r == 11) cyc(1'b1, 1'b1, 1'b1);
         else             cyc(1'b0, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/music_seq_ctrl.md
Name: music_seq_ctrl

Overview:
- Playback sequencer for the music/LED datapath. Walks a score ROM of (note, duration) entries and drives the tone generator with note codes.
- Generates the beat tick and the freeze (hold) level for the LED chaser.
- Accepts PLAY/PAUSE/STOP command pulses from the debounced button block.

Parameters:
- BEAT_CYCLES, 5000000, clock cycles per beat (min 4)
- GAP_CYCLES, 500000, cycles of silence at end of each note (1..BEAT_CYCLES-2)
- ADDR_W, 8, score ROM address width
- NOTE_W, 5, note code width (0 = rest)
- DUR_W, 4, duration field width in beats (0 = end-of-song marker)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- PLAY  in  1  one-cycle command pulse: start or resume
- PAUSE  in  1  one-cycle command pulse: pause
- STOP  in  1  one-cycle command pulse: stop and rewind
- rom_addr  out  ADDR_W  score ROM address
- rom_data  in  NOTE_W+DUR_W  {note, dur}; registered ROM, valid one cycle after rom_addr
- note  out  NOTE_W  current note code to tone generator
- note_on  out  1  tone enable
- beat_tick  out  1  one-cycle pulse at each beat boundary while playing
- led_freeze  out  1  hold level to the LED chaser
- state  out  3  current FSM state
- done  out  1  one-cycle pulse on end-of-song

Behaviour:
- Clocking and reset: single clock domain, all outputs registered. Asynchronous active-low reset; reset is decided as a single clock plus asynchronous active-low reset.
- Reset values: state=IDLE(0), rom_addr=0, note=0, note_on=0, beat_tick=0, led_freeze=1, done=0, beat counter=0, beats_left=0.
- States:
  - IDLE=0
  - FETCH=1: rom_addr stable
  - LOAD=2: rom_data sampled
  - PLAY=3
  - PAUSED=4
- Command priority when pulses coincide: STOP > PAUSE > PLAY.
- STOP in any state: next state IDLE; rom_addr=0, note=0, note_on=0, counters cleared.
- IDLE:
  - PLAY -> FETCH.
  - PAUSE is ignored.
- FETCH: unconditional -> LOAD after one cycle.
- LOAD: sample rom_data.
  - If dur==0: pulse done, rom_addr=0, -> IDLE.
  - Otherwise: note<=rom_data note field, beats_left<=dur, beat counter=0, -> PLAY.
  - Latency: PLAY sampled at edge k gives note_on=1 (if note!=0) after edge k+3.
- PLAY:
  - Beat counter runs 0..BEAT_CYCLES-1. beat_tick=1 for the cycle after the counter wraps.
  - On wrap: beats_left decrements.
  - If beats_left was 1: rom_addr increments (wraps 2^ADDR_W-1 -> 0) and the FSM moves to FETCH.
- note_on:
  - 1 in PLAY when note!=0, except in the final GAP_CYCLES of the last beat (beats_left==1 and counter >= BEAT_CYCLES-GAP_CYCLES).
  - 0 in all other states.
  - The note value holds through FETCH/LOAD until replaced.
- PAUSE in PLAY: -> PAUSED. Beat counter, beats_left, rom_addr and note are frozen; note_on=0.
- PAUSED:
  - PLAY -> PLAY, resuming the counter from its frozen value with no tick re-issued.
  - A second PAUSE is ignored.
- PLAY in FETCH/LOAD/PLAY: ignored. PAUSE in FETCH/LOAD: deferred; taken on the first PLAY cycle.
- led_freeze=1 in IDLE and PAUSED, otherwise 0.
- Reset asserted mid-note: immediate return to reset values regardless of state.

Optional Feature:
- Macro MUSIC_LOOP_EN.
- When defined: an end-of-song marker in LOAD sets rom_addr=0 and goes to FETCH (continuous loop). done still pulses once per pass, and led_freeze stays 0.
- When undefined: end-of-song stops in IDLE as described above.

Test Plan:
- Bench parameters: BEAT_CYCLES=8, GAP_CYCLES=2, ROM = {(3,2),(0x00 rest,1),(7,1),(x,0)}.
- Basic playback: PLAY pulse from IDLE -> note=3 with note_on high at k+3. note_on stays high for 14 cycles then low for 2. beat_tick pulses 8 cycles apart. rom_addr steps 0,1,2,3.
- End of song: rest entry keeps note_on=0 for 8 cycles; note 7 plays 6 on / 2 off. The dur=0 entry gives a done pulse, state=IDLE, rom_addr=0, led_freeze=1. With MUSIC_LOOP_EN, the FSM instead returns to FETCH at address 0.
- Pause/resume: PAUSE at beat counter=5 of note 3 -> state=4, note_on=0, led_freeze=1, counter held 20 cycles. PLAY resumes, and the next beat_tick follows exactly 3 cycles later.
- Simultaneous commands: PLAY+PAUSE+STOP in the same cycle during PLAY -> IDLE. PAUSE+PLAY together in PLAY -> PAUSED.
- Reset mid-note: assert RST_N=0 asynchronously between edges during PLAY -> all outputs immediately at reset values. PLAY after release restarts from address 0.
